// File: rtl/apb_slave.sv
// apb_slave -- APB completer holding a DEPTH x 8-bit register file.
//
// A transfer is captured in the setup phase (PSEL=1, PENABLE=0). The slave then
// spends WAIT_CYCLES cycles in ACCESS with PREADY low before it completes. Writes
// land on the completion edge. Reads return the addressed register
// combinationally during the completion cycle. Addresses >= DEPTH are
// out-of-range: their writes are dropped and their reads return 8'h00.
//
// Optional build macro:
//   APB_SLV_PSLVERR_EN  - drive PSLVERR=1 on the completing cycle of an
//                         out-of-range access. Without it PSLVERR is tied to 0.
//
// Ports:
//   i_pclk     clock, rising edge
//   i_presetn  asynchronous active-low reset
//   i_psel     select from master
//   i_penable  access-phase strobe
//   i_pwrite   1 = write, 0 = read
//   i_paddr    transfer address [7:0]
//   i_pwdata   write data [7:0]
//   o_prdata   read data [7:0] (0 except on a read completion)
//   o_pready   transfer completes on the edge where this is 1
//   o_pslverr  error response, only meaningful while o_pready=1
module apb_slave #(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic       i_pclk,
  input  logic       i_presetn,
  input  logic       i_psel,
  input  logic       i_penable,
  input  logic       i_pwrite,
  input  logic [7:0] i_paddr,
  input  logic [7:0] i_pwdata,
  output logic [7:0] o_prdata,
  output logic       o_pready,
  output logic       o_pslverr
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [7:0] r_addr, w_addr_next;
  logic [7:0] r_wdata, w_wdata_next;
  logic       r_write, w_write_next;

  logic [7:0] w_regs [DEPTH];
  logic [7:0] w_rd_val;
  logic       w_ready;
  logic       w_wr_en;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_write <= w_write_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_write_next = r_write;
    case (r_state)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; PENABLE=1 here is stray.
        if (i_psel && !i_penable) begin
          w_state_next = ST_ACCESS;
          w_addr_next  = i_paddr;
          w_wdata_next = i_pwdata;
          w_write_next = i_pwrite;
          w_cnt_next   = 4'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (!i_psel) begin
          // Master abandoned the transfer: drop it without touching registers.
          w_state_next = ST_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Gated by PSEL so an aborting master never sees a completion.
  assign w_ready = (r_state == ST_ACCESS) && (r_cnt == 4'd0) && i_psel;
  assign w_wr_en = w_ready && r_write;

  // One flop bank per register. Out-of-range addresses match no bank, so their
  // writes fall away naturally.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [7:0] r_q;
      always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
          r_q <= RESET_VAL;
        end else if (w_wr_en && (r_addr == 8'(gi))) begin
          r_q <= r_wdata;
        end
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  // Out-of-range reads match no entry and leave the default of zero.
  always_comb begin
    w_rd_val = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_addr == 8'(i)) begin
        w_rd_val = w_regs[i];
      end
    end
  end

  assign o_pready = w_ready;
  assign o_prdata = (w_ready && !r_write) ? w_rd_val : 8'h00;

`ifdef APB_SLV_PSLVERR_EN
  logic w_oor;
  assign w_oor     = ({1'b0, r_addr} >= 9'(DEPTH));
  assign o_pslverr = w_ready && w_oor;
`else
  assign o_pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Testbench for apb_slave. Three slaves share one APB bus, each on its own PSEL
// line, with WAIT_CYCLES of 0, 2 and 3. The stimulus thread pushes the expected
// completion of each transfer into a scoreboard queue. A monitor on the falling
// edge pops an entry whenever the selected slave shows PREADY and compares
// PRDATA, PSLVERR and the number of stall cycles.
module tb_apb_slave;
  localparam int NS    = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          presetn = 1'b0;
  logic [NS-1:0] psel = '0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [7:0]    paddr = 8'h00;
  logic [7:0]    pwdata = 8'h00;
  logic [7:0]    prdata [NS];
  logic          pready [NS];
  logic          pslverr [NS];

  typedef struct {
    int         slv;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         err;
    int         waits;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model [NS][256];
  int         cur = 0;
  int         wait_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slv
      localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
      apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WC), .RESET_VAL(8'h00)) u_dut (
        .i_pclk   (clk),
        .i_presetn(presetn),
        .i_psel   (psel[gi]),
        .i_penable(penable),
        .i_pwrite (pwrite),
        .i_paddr  (paddr),
        .i_pwdata (pwdata),
        .o_prdata (prdata[gi]),
        .o_pready (pready[gi]),
        .o_pslverr(pslverr[gi])
      );
    end
  endgenerate

  function automatic int wc_of(input int s);
    if (s == 0) return 0;
    if (s == 1) return 2;
    return 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 256; a++)
        model[s][a] = 8'h00;
  endtask

  task automatic bus_idle(input int cycles);
    psel = '0;
    penable = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // One complete APB transfer. Leaves PSEL/PENABLE high so the next call
  // starts its setup phase straight after the completion edge.
  task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   n;
    bit   oor;
    oor     = (a >= DEPTH);
    e.slv   = s;
    e.wr    = wr;
    e.addr  = a;
    e.data  = (wr || oor) ? 8'h00 : model[s][a];
`ifdef APB_SLV_PSLVERR_EN
    e.err   = oor;
`else
    e.err   = 1'b0;
`endif
    e.waits = wc_of(s);
    sb.push_back(e);
    cur     = s;
    psel    = '0;
    psel[s] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge clk); #1;
    penable = 1'b1;
    // Address and data are only sampled in setup, so scramble them now.
    paddr   = 8'($urandom);
    pwdata  = 8'($urandom);
    n = 0;
    while (!pready[s] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pready[s]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: slave %0d addr %02h never raised pready", s, a);
      sb.delete(sb.size() - 1);
      psel = '0;
      penable = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (wr && !oor) model[s][a] = d;
    end
  endtask

  // Monitor: pops on every completion of the selected slave and counts stalls.
  always @(negedge clk) begin
    if (presetn && psel[cur] && penable) begin
      if (pready[cur]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready: slave %0d completed with nothing pending", cur);
        end else begin
          mon_e = sb.pop_front();
          check("slave", cur, mon_e.slv);
          check("prdata", prdata[cur], mon_e.data);
          check("pslverr", pslverr[cur], mon_e.err);
          check("waits", wait_cnt, mon_e.waits);
          $display("txn slave=%0d %s addr=%02h prdata=%02h pslverr=%0b waits=%0d",
                   cur, mon_e.wr ? "WR" : "RD", mon_e.addr, prdata[cur], pslverr[cur], wait_cnt);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    for (int s = 0; s < NS; s++) begin
      check("rst_prdata", prdata[s], 8'h00);
      check("rst_pready", pready[s], 1'b0);
      check("rst_pslverr", pslverr[s], 1'b0);
    end
    #11;
    presetn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write/read.
    xfer(0, 1'b1, 8'd3, 8'hA5);
    xfer(0, 1'b0, 8'd3, 8'h00);
    // Two-cycle stall write/read.
    xfer(1, 1'b1, 8'd7, 8'h3C);
    xfer(1, 1'b0, 8'd7, 8'h00);
    // Back-to-back with no idle gaps.
    xfer(0, 1'b1, 8'd1, 8'h11);
    xfer(0, 1'b1, 8'd2, 8'h22);
    xfer(0, 1'b0, 8'd1, 8'h00);
    xfer(0, 1'b0, 8'd2, 8'h00);
    // Out-of-range write/read, then confirm every legal register.
    xfer(0, 1'b1, 8'h20, 8'hFF);
    xfer(0, 1'b0, 8'h20, 8'h00);
    for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, 8'(i), 8'h00);
    bus_idle(2);

    // Reset during the second wait cycle of a write on the 3-wait slave.
    cur = 2;
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'd5;
    pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    presetn = 1'b0;
    #1;
    for (int s = 0; s < NS; s++) begin
      check("midrst_prdata", prdata[s], 8'h00);
      check("midrst_pready", pready[s], 1'b0);
      check("midrst_pslverr", pslverr[s], 1'b0);
    end
    psel = '0;
    penable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    presetn = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'd5, 8'h00);
    xfer(0, 1'b0, 8'd3, 8'h00);
    xfer(1, 1'b0, 8'd7, 8'h00);

    // Stray access phase without setup, then an abort mid-wait.
    xfer(1, 1'b1, 8'd9, 8'h42);
    cur = 1;
    psel = 3'b010;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 8'd9;
    pwdata = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("nosetup_pready", pready[1], 1'b0);
    end
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_wait_pready", pready[1], 1'b0);
    @(posedge clk); #1;
    psel = '0;
    penable = 1'b0;
    #1;
    check("abort_drop_pready", pready[1], 1'b0);
    @(posedge clk); #1;
    check("abort_after_pready", pready[1], 1'b0);
    xfer(1, 1'b0, 8'd9, 8'h00);

    // Randomised traffic across all three slaves, including out-of-range hits.
    for (int k = 0; k < 150; k++) begin
      xfer(int'($urandom_range(0, NS - 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 23)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) bus_idle(int'($urandom_range(1, 3)));
    end
    bus_idle(5);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
Name: apb_slave

Overview:
APB completer (slave) that answers the transfers issued by the team's APB master FSM.
- Holds a DEPTH-entry x 8-bit register file.
- Captures address, direction and write data in the SETUP phase.
- Inserts a parameterised number of wait states before asserting PREADY in the ACCESS phase.
- Returns read data on PRDATA.
- Sits on the peripheral side of the 8-bit APB link, one instance per PSEL line.

Parameters:
DEPTH, 16, number of 8-bit registers; valid addresses 0..DEPTH-1; legal range 1..256
WAIT_CYCLES, 0, PREADY-low cycles inserted at the start of every ACCESS phase; legal range 0..15
RESET_VAL, 8'h00, value loaded into every register on reset

Ports:
PCLK  input  1  clock; all state updates on rising edge
PRESETn  input  1  asynchronous active-low reset
PSEL  input  1  select from master
PENABLE  input  1  access-phase strobe from master
PWRITE  input  1  1 = write, 0 = read
PADDR  input  8  transfer address
PWDATA  input  8  write data
PRDATA  output  8  read data
PREADY  output  1  transfer completes on the edge where PREADY=1 and the slave is in ACCESS
PSLVERR  output  1  error response; valid only while PREADY=1

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - state=IDLE, wait counter=0, latched addr/dir/data=0.
  - All registers = RESET_VAL.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset mid-transfer aborts it; no register is written.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase): latch PADDR, PWRITE, PWDATA; load wait counter with WAIT_CYCLES; go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE (no preceding setup) is ignored; stay in IDLE.
- ACCESS:
  - PREADY = (counter==0); it is a combinational decode of the registered state and counter.
  - While counter!=0 and PSEL=1: decrement by 1 per cycle; PREADY=0.
  - On an edge with PREADY=1:
    - Write: registers[addr_q] <= wdata_q.
    - Go to IDLE.
  - PSEL=0 while in ACCESS (master abort): go to IDLE; no write; PREADY=0.
- Latency from the setup-phase edge to the completion edge is WAIT_CYCLES+1 cycles. WAIT_CYCLES=0 gives a zero-wait transfer.
- Back-to-back transfers: after a completion the slave is in IDLE and accepts the master's next setup phase on the following edge, so there is no dead cycle beyond APB's own SETUP cycle.
- PRDATA:
  - In ACCESS with PREADY=1 and a read: registers[addr_q] (combinational from latched addr).
  - Otherwise: 0.
- Register addressing and out-of-range handling:
  - Register index is addr_q, using only addresses < DEPTH.
  - An address >= DEPTH is out-of-range: writes are dropped and reads return 8'h00.
  - PSLVERR follows the Optional Feature below.
- Sampling rules:
  - PWDATA and PADDR are sampled only in the setup phase; changes during ACCESS have no effect.
  - The read value is the register content at the completion cycle, which includes the effect of any write completed earlier.

Optional Feature:
Macro APB_SLV_PSLVERR_EN.
- Defined:
  - PSLVERR = 1 during the completing cycle (PREADY=1) when addr_q >= DEPTH, for reads and writes; 0 at all other times.
  - Write data is still dropped.
  - PRDATA is 8'h00 for an out-of-range read.
- Not defined: PSLVERR is tied to 0; out-of-range accesses complete silently with the same drop/zero behaviour.

Test Plan:
1. WAIT_CYCLES=0: write 8'hA5 to addr 3, then read addr 3 -> each transfer completes in the first ACCESS cycle with PREADY=1; the read returns PRDATA=8'hA5 and PSLVERR=0.
2. WAIT_CYCLES=2: write 8'h3C to addr 7 -> PREADY=0 for exactly 2 ACCESS cycles, then 1; a read of addr 7 returns 8'h3C after the same 2-cycle stall.
3. Back-to-back write addr1=8'h11, write addr2=8'h22, read addr1, read addr2 with no IDLE gaps -> reads return 8'h11 and 8'h22; no dropped or duplicated transfer.
4. DEPTH=16, write 8'hFF to addr 8'h20, then read 8'h20 -> PRDATA=8'h00. With APB_SLV_PSLVERR_EN, PSLVERR=1 on both completing cycles; without it, PSLVERR=0. Registers 0..15 are unchanged.
5. WAIT_CYCLES=3: assert PRESETn=0 during the 2nd wait cycle of a write to addr 5 with 8'h77 -> outputs go to 0 immediately; after release, a read of addr 5 returns RESET_VAL.
6. PSEL=1, PENABLE=1 with no setup cycle, then master drops PSEL mid-wait on a legal write -> the slave stays/returns IDLE, PREADY is never asserted, and the target register is unchanged.
